modulo_counter: RTL and testbench

Parametrised modulo counter for the clock/calendar datapath. It generalises the fixed 0..59 second counter to any range `MIN_VAL..MAX_VAL`, with several additions:
- a run-time upper bound for day-of-month;
- up/down counting;
- synchronous load;
- borrow output;
- press-and-hold auto-repeat for the manual set buttons.

Instances chain `carry_out`/`borrow_out` into the next stage's `tick`.

---
 rtl/modulo_counter.sv | 165 ++++++++++++++++
 tb/tb_modulo_counter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_counter.sv
// Modulo counter with run-time bound, up/down ticks, load, and button auto-repeat.
// Stages chain carry_out/borrow_out into the next stage's tick.
module modulo_counter #(
  parameter int WIDTH    = 6,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 59,
  parameter int RST_VAL  = 0,
  parameter int HOLD_CYC = 500,
  parameter int RPT_CYC  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             count_dir,
  input  logic             manual_set,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_in,
  output logic [WIDTH-1:0] value,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             at_max
);

  localparam int RPT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  localparam logic [CNT_W-1:0] HOLD_W  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] RPT_W   = CNT_W'(RPT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_HOLD,
    RS_RPT
  } rpt_state_e;

  typedef struct packed {
    logic up_q;
    logic down_q;
  } btn_hist_t;

  rpt_state_e       st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  btn_hist_t        hist, hist_n;

  logic [WIDTH-1:0] eff_max;
  logic [WIDTH-1:0] max_lo, load_lo, load_sat;
  logic [WIDTH-1:0] val_n, val_inc, val_dec;
  logic             carry_n, borrow_n;
  logic             up_only, dn_only, up_rise, dn_rise, step;

  // Lower clamps are only generated when MIN_VAL > 0; otherwise they are
  // unsigned compares against zero and always false.
  if (MIN_VAL > 0) begin : g_lo_clamp
    assign max_lo  = (max_in   < MIN_W) ? MIN_W : max_in;
    assign load_lo = (load_val < MIN_W) ? MIN_W : load_val;
  end else begin : g_lo_pass
    assign max_lo  = max_in;
    assign load_lo = load_val;
  end

  assign eff_max  = (max_lo > MAX_W) ? MAX_W : max_lo;
  assign load_sat = (load_lo > eff_max) ? eff_max : load_lo;
  assign at_max   = (value == eff_max);

  assign up_only = up & ~down;
  assign dn_only = down & ~up;
  assign up_rise = up_only & ~hist.up_q;
  assign dn_rise = dn_only & ~hist.down_q;

  // Out-of-range values (bound just dropped) step into range rather than away.
  assign val_inc = (value >= eff_max) ? MIN_W : value + ONE_W;
  assign val_dec = (value <= MIN_W)   ? eff_max :
                   (value >  eff_max) ? eff_max : value - ONE_W;

  // Repeat FSM: a lone-button press steps immediately and arms the hold timer.
  // Anything else (release, both buttons, load, leaving manual mode) disarms
  // it, so a button still held afterwards stays inert until re-pressed.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    step   = 1'b0;
    hist_n = '{up_q: manual_set & up, down_q: manual_set & down};
    if (!manual_set || load || !(up_only || dn_only)) begin
      st_n  = RS_IDLE;
      cnt_n = '0;
    end else if (up_rise || dn_rise) begin
      step  = 1'b1;
      st_n  = RS_HOLD;
      cnt_n = CNT_ONE;
    end else begin
      case (st)
        RS_HOLD: begin
          if (cnt == HOLD_W) begin
            step  = 1'b1;
            st_n  = RS_RPT;
            cnt_n = CNT_ONE;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        RS_RPT: begin
          if (cnt == RPT_W) begin
            step  = 1'b1;
            cnt_n = CNT_ONE;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: begin
          st_n  = RS_IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    val_n    = value;
    carry_n  = 1'b0;
    borrow_n = 1'b0;
    if (load) begin
      val_n = load_sat;
    end else if (manual_set && step) begin
      val_n = up ? val_inc : val_dec;
    end else if (!manual_set && tick) begin
      if (!count_dir) begin
        val_n   = val_inc;
        carry_n = (value >= eff_max);
      end else begin
        val_n    = val_dec;
        borrow_n = (value <= MIN_W);
      end
    end else if (value > eff_max) begin
      val_n = eff_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value      <= RST_W;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      st         <= RS_IDLE;
      cnt        <= '0;
      hist       <= '0;
    end else begin
      value      <= val_n;
      carry_out  <= carry_n;
      borrow_out <= borrow_n;
      st         <= st_n;
      cnt        <= cnt_n;
      hist       <= hist_n;
    end
  end

endmodule

// File: tb/tb_modulo_counter.sv
// Directed bench: instance A is a 0..59 counter with short repeat timing,
// instance B a 1..31 day-of-month counter.
module tb_modulo_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, tick_a, dir_a, man_a, up_a, down_a, load_a;
  logic [5:0] load_val_a, max_in_a, value_a;
  logic       carry_a, borrow_a, at_max_a;

  logic       rst_n_b, tick_b, dir_b, man_b, up_b, down_b, load_b;
  logic [4:0] load_val_b, max_in_b, value_b;
  logic       carry_b, borrow_b, at_max_b;

  int checks = 0;
  int errors = 0;

  int exp_rpt [10] = '{59, 59, 59, 59, 59, 0, 0, 1, 1, 2};
  int exp_rst [8]  = '{1, 1, 1, 1, 1, 2, 2, 3};

  modulo_counter #(
    .WIDTH(6), .MIN_VAL(0), .MAX_VAL(59), .RST_VAL(0), .HOLD_CYC(5), .RPT_CYC(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .tick(tick_a), .count_dir(dir_a),
    .manual_set(man_a), .up(up_a), .down(down_a), .load(load_a),
    .load_val(load_val_a), .max_in(max_in_a), .value(value_a),
    .carry_out(carry_a), .borrow_out(borrow_a), .at_max(at_max_a)
  );

  modulo_counter #(
    .WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .RST_VAL(1), .HOLD_CYC(500), .RPT_CYC(100)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .tick(tick_b), .count_dir(dir_b),
    .manual_set(man_b), .up(up_b), .down(down_b), .load(load_b),
    .load_val(load_val_b), .max_in(max_in_b), .value(value_b),
    .carry_out(carry_b), .borrow_out(borrow_b), .at_max(at_max_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_a = 0; tick_a = 0; dir_a = 0; man_a = 0; up_a = 0; down_a = 0;
    load_a = 0; load_val_a = '0; max_in_a = 6'd59;
    rst_n_b = 0; tick_b = 0; dir_b = 0; man_b = 0; up_b = 0; down_b = 0;
    load_b = 0; load_val_b = '0; max_in_b = 5'd28;
    cyc(); cyc();
    checks++;
    if (value_a !== 6'd0 || carry_a !== 1'b0 || borrow_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a value=%0d carry=%b borrow=%b expected 0/0/0", value_a, carry_a, borrow_a);
    end
    checks++;
    if (value_b !== 5'd1 || carry_b !== 1'b0 || borrow_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b value=%0d carry=%b borrow=%b expected 1/0/0", value_b, carry_b, borrow_b);
    end
    rst_n_a = 1; rst_n_b = 1;
    cyc();
  endtask

  task automatic test_tick_up_wrap();
    tick_a = 1; dir_a = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      checks++;
      if (value_a !== 6'(i % 60) || carry_a !== (i == 60)) begin
        errors++;
        $display("FAIL tick_up[%0d] value=%0d carry=%b expected %0d/%b", i, value_a, carry_a, i % 60, i == 60);
      end
      if (i == 59) begin
        checks++;
        if (at_max_a !== 1'b1) begin
          errors++;
          $display("FAIL tick_up_at_max got %b expected 1", at_max_a);
        end
      end
    end
    tick_a = 0;
    cyc();
    checks++;
    if (value_a !== 6'd0 || carry_a !== 1'b0) begin
      errors++;
      $display("FAIL tick_up_idle value=%0d carry=%b expected 0/0", value_a, carry_a);
    end
  endtask

  task automatic test_tick_down_wrap();
    dir_b = 1; tick_b = 1;
    cyc();
    checks++;
    if (value_b !== 5'd28 || borrow_b !== 1'b1 || carry_b !== 1'b0) begin
      errors++;
      $display("FAIL tick_down_wrap value=%0d borrow=%b carry=%b expected 28/1/0", value_b, borrow_b, carry_b);
    end
    cyc();
    checks++;
    if (value_b !== 5'd27 || borrow_b !== 1'b0) begin
      errors++;
      $display("FAIL tick_down_step value=%0d borrow=%b expected 27/0", value_b, borrow_b);
    end
    tick_b = 0; dir_b = 0;
    cyc();
    checks++;
    if (value_b !== 5'd27 || borrow_b !== 1'b0) begin
      errors++;
      $display("FAIL tick_down_idle value=%0d borrow=%b expected 27/0", value_b, borrow_b);
    end
  endtask

  task automatic test_clamp_load();
    max_in_b = 5'd31; load_b = 1; load_val_b = 5'd30;
    cyc();
    load_b = 0;
    checks++;
    if (value_b !== 5'd30 || at_max_b !== 1'b0) begin
      errors++;
      $display("FAIL load_30 value=%0d at_max=%b expected 30/0", value_b, at_max_b);
    end
    max_in_b = 5'd28;
    cyc();
    checks++;
    if (value_b !== 5'd28 || carry_b !== 1'b0 || borrow_b !== 1'b0 || at_max_b !== 1'b1) begin
      errors++;
      $display("FAIL clamp_28 value=%0d c=%b b=%b at_max=%b expected 28/0/0/1", value_b, carry_b, borrow_b, at_max_b);
    end
    load_b = 1; load_val_b = 5'd45 & 5'h1f;
    load_val_b = 5'd29;
    cyc();
    checks++;
    if (value_b !== 5'd28) begin
      errors++;
      $display("FAIL load_sat_hi value=%0d expected 28", value_b);
    end
    load_val_b = 5'd0;
    cyc();
    checks++;
    if (value_b !== 5'd1) begin
      errors++;
      $display("FAIL load_sat_lo value=%0d expected 1", value_b);
    end
    max_in_b = 5'd31; load_val_b = 5'd31;
    cyc();
    load_b = 0;
    checks++;
    if (value_b !== 5'd31 || at_max_b !== 1'b1) begin
      errors++;
      $display("FAIL load_31 value=%0d at_max=%b expected 31/1", value_b, at_max_b);
    end
    max_in_b = 5'd0;
    #1;
    checks++;
    if (at_max_b !== 1'b0) begin
      errors++;
      $display("FAIL at_max_comb got %b expected 0", at_max_b);
    end
    cyc();
    checks++;
    if (value_b !== 5'd1 || at_max_b !== 1'b1) begin
      errors++;
      $display("FAIL clamp_min value=%0d at_max=%b expected 1/1", value_b, at_max_b);
    end
  endtask

  task automatic test_manual_repeat();
    load_a = 1; load_val_a = 6'd58;
    cyc();
    load_a = 0;
    man_a = 1; up_a = 1; tick_a = 1;
    for (int j = 0; j < 10; j++) begin
      cyc();
      checks++;
      if (value_a !== 6'(exp_rpt[j]) || carry_a !== 1'b0) begin
        errors++;
        $display("FAIL repeat[k+%0d] value=%0d carry=%b expected %0d/0", j, value_a, carry_a, exp_rpt[j]);
      end
    end
    up_a = 0;
    cyc();
    checks++;
    if (value_a !== 6'd2) begin
      errors++;
      $display("FAIL repeat_release value=%0d expected 2", value_a);
    end
  endtask

  task automatic test_both_buttons();
    up_a = 1; down_a = 1;
    for (int j = 0; j < 8; j++) begin
      cyc();
      checks++;
      if (value_a !== 6'd2) begin
        errors++;
        $display("FAIL both[%0d] value=%0d expected 2", j, value_a);
      end
    end
    down_a = 0;
    for (int j = 0; j < 8; j++) begin
      cyc();
      checks++;
      if (value_a !== 6'd2) begin
        errors++;
        $display("FAIL up_after_both[%0d] value=%0d expected 2", j, value_a);
      end
    end
    up_a = 0;
    cyc();
    up_a = 1;
    cyc();
    checks++;
    if (value_a !== 6'd3) begin
      errors++;
      $display("FAIL repress value=%0d expected 3", value_a);
    end
    up_a = 0; tick_a = 0;
    cyc();
  endtask

  task automatic test_reset_mid_hold();
    load_a = 1; load_val_a = 6'd16;
    cyc();
    load_a = 0; up_a = 1;
    cyc(); cyc(); cyc();
    checks++;
    if (value_a !== 6'd17) begin
      errors++;
      $display("FAIL hold_17 value=%0d expected 17", value_a);
    end
    rst_n_a = 0;
    #2;
    checks++;
    if (value_a !== 6'd0) begin
      errors++;
      $display("FAIL async_reset value=%0d expected 0", value_a);
    end
    cyc();
    rst_n_a = 1;
    for (int j = 0; j < 8; j++) begin
      cyc();
      checks++;
      if (value_a !== 6'(exp_rst[j])) begin
        errors++;
        $display("FAIL post_reset[k+%0d] value=%0d expected %0d", j, value_a, exp_rst[j]);
      end
    end
    up_a = 0; man_a = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_tick_up_wrap();
    test_tick_down_wrap();
    test_clamp_load();
    test_manual_repeat();
    test_both_buttons();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
